tile_dma: RTL and testbench
===========================

# tile_dma

Tile DMA engine directly downstream of the tensorcore scheduler's memory-request port. It accepts one tile request at a time (C, A or B tile read, or result write-back), moves the tile word by word between the external memory bus and the on-chip tile SRAMs, and pulses `finish` back to the scheduler when the transfer is complete. Reads are pipelined with a bounded number of outstanding requests. Write-back streams out of the result SRAM with backpressure.

## Interface
Parameters:
- `WIDTH`, 32: data word width (bits); address step per word = WIDTH/8 bytes
- `ADDR_W`, 32: memory address width
- `WORDS_A`, 128: words per A tile (8x16)
- `WORDS_B`, 256: words per B tile (16x16)
- `WORDS_C`, 64: words per C/result tile (8x8)
- `OUTS`, 4: max outstanding read requests (power of two, ≥1)

Ports:
- `clk`  in  1  clock; all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `request_valid`  in  1  single-cycle request strobe from scheduler
- `sel`  in  3  001=C, 010=A, 100=B, 000=result write-back
- `issend`  in  1  1=write to memory (valid only with sel=000), 0=read
- `base_a`, `base_b`, `base_c`, `base_d`  in  ADDR_W each  tile base byte addresses (D = result)
- `finish`  out  1  one-cycle pulse: transfer complete
- `busy`  out  1  high from accept until the `finish` cycle inclusive
- `err`  out  1  one-cycle pulse: request rejected
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_we` out 1, `mem_req_addr` out ADDR_W, `mem_req_wdata` out WIDTH: memory request channel
- `mem_rsp_valid` in 1, `mem_rsp_rdata` in WIDTH: in-order read responses, no backpressure
- `buf_we` out 1, `buf_sel` out 3, `buf_waddr` out 8, `buf_wdata` out WIDTH: tile SRAM write port
- `buf_re` out 1, `buf_raddr` out 8, `buf_rdata` in WIDTH: result SRAM read port, 1-cycle read latency

## Operation
- States: IDLE, RD, WB_READ, WB_SEND, DONE.
- IDLE: on `request_valid`, latch `sel`/`issend`, word count N (A/B/C by `sel`; WORDS_C for write-back), and base address (A/B/C/D). Then go to RD (read) or WB_READ (sel=000 with issend=1).
- Illegal combinations (sel not one-hot and not 000; sel=000 with issend=0; issend=1 with nonzero sel): `err` pulse, stay IDLE.
- `request_valid` while not IDLE: ignored, `err` pulse, transfer unaffected.
- RD issue side: `mem_req_valid`=1, `mem_req_we`=0, addr = base + i*(WIDTH/8). Index i advances on valid&&ready. Valid drops once N requests are accepted, or when outstanding==OUTS.
- Outstanding counter: +1 on accept, -1 on `mem_rsp_valid`, both applied in the same cycle. A response arriving in the same cycle as a full counter frees a slot for the next cycle, not the current one.
- RD response side: each response is registered and written next cycle with `buf_we`=1, `buf_sel`=latched sel, `buf_waddr`=response index j (0..N-1), `buf_wdata`=rdata.
- RD exits to DONE the cycle after the write for j=N-1.
- WB_READ: `buf_re`=1, `buf_raddr`=k → WB_SEND.
- WB_SEND: `mem_req_valid`=1, `mem_req_we`=1, addr = base_d + k*(WIDTH/8), wdata = captured `buf_rdata`. Addr and wdata are held stable until ready.
  - On accept with k<N-1: k++, back to WB_READ.
  - On accept with k=N-1: DONE.
- DONE: `finish`=1 for one cycle, return to IDLE.
- Indices are 9-bit internally. Addresses wrap modulo 2^ADDR_W with no error.
- `mem_rsp_valid` in IDLE/WB_*: dropped, no buffer write.

## Timing
- Reset (async assert, sync release): state IDLE; all counters 0; all outputs 0.
- Reset mid-transfer aborts the transfer immediately, with no `finish`. Late responses after reset are dropped.
- Accept at cycle 0 → first `mem_req_valid` at cycle 1.
- Read: ready always high, response latency R, OUTS≥R+1 gives one request per cycle. Last `buf_we` at cycle N+R+1, `finish` at N+R+2.
- Write-back: 2 cycles/word minimum; with ready high, `finish` at cycle 2N+1.
- `busy` equals (state != IDLE).

## Test plan
- Reset, then drive no requests for 10 cycles → all outputs 0, no `mem_req_valid`.
- A read (sel=010, base_a=0x1000), ready=1, rsp latency 1, rdata=addr → 128 requests at 0x1000..0x11FC; `buf_waddr` 0..127 with matching data; one `finish` at cycle 131.
- B read, OUTS=4, rsp latency 10, random `mem_req_ready` → never >4 outstanding; all 256 buffer writes in order; exactly one `finish`.
- Write-back (sel=000, issend=1, base_d=0x8000), SRAM preloaded with word i = i, ready low 3 cycles on every 5th word → 64 writes with addr 0x8000+4i, wdata=i, addr/wdata stable while stalled; `finish` once.
- `request_valid` mid-transfer and sel=011 in IDLE → `err` pulse each time; ongoing transfer completes unchanged.
- Assert `rst` after 20 words of a C read → outputs 0 immediately, no `finish`. A fresh request then completes normally, and stale responses are ignored.

Source files
------------

// File: rtl/tile_dma.sv
// Tile DMA engine: moves A/B/C tiles from memory into the tile SRAMs, and
// streams the result tile from its SRAM back to memory.
module tile_dma #(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 32,
   parameter int WORDS_A = 128,
   parameter int WORDS_B = 256,
   parameter int WORDS_C = 64,
   parameter int OUTS    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              request_valid,
   input  logic [2:0]        sel,
   input  logic              issend,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [ADDR_W-1:0] base_c,
   input  logic [ADDR_W-1:0] base_d,
   output logic              finish,
   output logic              busy,
   output logic              err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [WIDTH-1:0]  mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic [WIDTH-1:0]  mem_rsp_rdata,
   output logic              buf_we,
   output logic [2:0]        buf_sel,
   output logic [7:0]        buf_waddr,
   output logic [WIDTH-1:0]  buf_wdata,
   output logic              buf_re,
   output logic [7:0]        buf_raddr,
   input  logic [WIDTH-1:0]  buf_rdata
);

   typedef enum logic [2:0] {IDLE, RD, WB_READ, WB_SEND, DONE} state_t;

   localparam int OW = $clog2(OUTS) + 1;
   localparam logic [OW-1:0]     OUTS_V = OW'(OUTS);
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(WIDTH / 8);

   state_t             state, state_nx;
   logic [2:0]         sel_q;
   logic [8:0]         num_q;
   logic [ADDR_W-1:0]  base_q;
   logic [8:0]         idx_q;       // issue index in RD, word index k in write-back
   logic [8:0]         rsp_idx_q;
   logic [OW-1:0]      outst_q;
   logic               rsp_v_q;
   logic [WIDTH-1:0]   rsp_d_q;
   logic [WIDTH-1:0]   wdata_q;
   logic               snd_first_q;

   logic sel_onehot, rd_ok, wb_ok, accept;
   logic issue_ok, req_acc, rsp_ok, last_wr, last_idx;

   always_comb begin
      sel_onehot = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
      rd_ok      = sel_onehot && !issend;
      wb_ok      = (sel == 3'b000) && issend;
      accept     = (state == IDLE) && request_valid && (rd_ok || wb_ok);
      issue_ok   = (state == RD) && (idx_q < num_q) && (outst_q != OUTS_V);
      req_acc    = issue_ok && mem_req_ready;
      // responses with nothing outstanding are leftovers from an aborted transfer
      rsp_ok     = (state == RD) && mem_rsp_valid && (outst_q != '0);
      last_wr    = (state == RD) && rsp_v_q && (rsp_idx_q == num_q - 9'd1);
      last_idx   = (idx_q == num_q - 9'd1);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = wb_ok ? WB_READ : RD;
         RD:      if (last_wr) state_nx = DONE;
         WB_READ: state_nx = WB_SEND;
         WB_SEND: if (mem_req_ready) state_nx = last_idx ? DONE : WB_READ;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      finish        = (state == DONE);
      busy          = (state != IDLE);
      err           = request_valid && !accept;
      mem_req_valid = issue_ok || (state == WB_SEND);
      mem_req_we    = (state == WB_SEND);
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      if (mem_req_valid) mem_req_addr = base_q + ADDR_W'(idx_q) * STEP;
      // SRAM data arrives on the first send cycle; later stall cycles replay the capture
      if (state == WB_SEND) mem_req_wdata = snd_first_q ? buf_rdata : wdata_q;
      buf_we    = (state == RD) && rsp_v_q;
      buf_sel   = '0;
      buf_waddr = '0;
      buf_wdata = '0;
      if (buf_we) begin
         buf_sel   = sel_q;
         buf_waddr = rsp_idx_q[7:0];
         buf_wdata = rsp_d_q;
      end
      buf_re    = (state == WB_READ);
      buf_raddr = buf_re ? idx_q[7:0] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q       <= '0;
         num_q       <= '0;
         base_q      <= '0;
         idx_q       <= '0;
         rsp_idx_q   <= '0;
         outst_q     <= '0;
         rsp_v_q     <= 1'b0;
         rsp_d_q     <= '0;
         wdata_q     <= '0;
         snd_first_q <= 1'b0;
      end else begin
         rsp_v_q     <= rsp_ok;
         snd_first_q <= (state == WB_READ);
         if (rsp_ok) rsp_d_q <= mem_rsp_rdata;
         if (accept) begin
            sel_q     <= sel;
            idx_q     <= '0;
            rsp_idx_q <= '0;
            outst_q   <= '0;
            case (sel)
               3'b001:  begin num_q <= 9'(WORDS_C); base_q <= base_c; end
               3'b010:  begin num_q <= 9'(WORDS_A); base_q <= base_a; end
               3'b100:  begin num_q <= 9'(WORDS_B); base_q <= base_b; end
               default: begin num_q <= 9'(WORDS_C); base_q <= base_d; end
            endcase
         end else begin
            outst_q <= outst_q + OW'(req_acc) - OW'(rsp_ok);
            if (req_acc) idx_q <= idx_q + 9'd1;
            if (buf_we) rsp_idx_q <= rsp_idx_q + 9'd1;
            if (state == WB_SEND) begin
               if (snd_first_q) wdata_q <= buf_rdata;
               if (mem_req_ready) idx_q <= idx_q + 9'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tile_dma.sv
// Scoreboard bench for tile_dma: a memory/SRAM responder runs in the
// background, scenario tasks queue expected traffic and drain it per cycle.
module tb_tile_dma;
   localparam int WIDTH = 32;
   localparam int ADDR_W = 32;
   localparam int OUTS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic request_valid = 1'b0;
   logic [2:0] sel = '0;
   logic issend = 1'b0;
   logic [ADDR_W-1:0] base_a = '0, base_b = '0, base_c = '0, base_d = '0;
   logic finish, busy, err;
   logic mem_req_valid, mem_req_we;
   logic mem_req_ready = 1'b0;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [WIDTH-1:0] mem_req_wdata;
   logic mem_rsp_valid = 1'b0;
   logic [WIDTH-1:0] mem_rsp_rdata = '0;
   logic buf_we, buf_re;
   logic [2:0] buf_sel;
   logic [7:0] buf_waddr, buf_raddr;
   logic [WIDTH-1:0] buf_wdata;
   logic [WIDTH-1:0] buf_rdata = '0;

   tile_dma #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .WORDS_A(128), .WORDS_B(256),
              .WORDS_C(64), .OUTS(OUTS)) dut (
      .clk(clk), .rst(rst), .request_valid(request_valid), .sel(sel), .issend(issend),
      .base_a(base_a), .base_b(base_b), .base_c(base_c), .base_d(base_d),
      .finish(finish), .busy(busy), .err(err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .buf_we(buf_we), .buf_sel(buf_sel), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
      .buf_re(buf_re), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic [31:0] data; } rsp_t;
   typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
   typedef struct { logic [2:0] sel; logic [7:0] waddr; logic [31:0] wdata; } bw_t;

   rsp_t pend[$];
   req_t exp_req[$];
   bw_t  exp_buf[$];
   logic [31:0] sram [0:255];

   int cyc = 0;
   int lat = 1;
   int rdy_mode = 0;   // 0: always ready, 1: random, 2: write-back stall pattern
   int wb_words = 0;
   int stall = 0;
   int checks = 0;
   int errors = 0;

   // memory and result-SRAM responder; ready decided at negedge, data after posedge
   initial begin : responder
      bit rdy, re;
      logic [7:0] ra;
      rsp_t r;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            1: rdy = 1'($urandom_range(0, 1));
            2: begin
               if (mem_req_valid && mem_req_we && (wb_words % 5 == 4) && stall < 3) begin
                  rdy = 1'b0;
                  stall++;
               end else rdy = 1'b1;
            end
            default: rdy = 1'b1;
         endcase
         mem_req_ready = rdy;
         if (mem_req_valid && rdy && !mem_req_we) pend.push_back('{cyc + lat, mem_req_addr});
         if (mem_req_valid && rdy && mem_req_we) begin
            wb_words++;
            stall = 0;
         end
         re = buf_re;
         ra = buf_raddr;
         @(posedge clk);
         #1;
         cyc++;
         mem_rsp_valid = 1'b0;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = r.data;
         end
         if (re) buf_rdata = sram[ra];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic push_read(input logic [2:0] s, input logic [31:0] base, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = base + 32'(4 * i);
         exp_req.push_back('{a, 1'b0, 32'h0});
         exp_buf.push_back('{s, 8'(i), a});
      end
   endtask

   task automatic issue_req(input logic [2:0] s, input logic isd, input logic exp_err);
      @(negedge clk);
      #1;
      sel = s;
      issend = isd;
      request_valid = 1'b1;
      #1;
      checks++;
      if (err !== exp_err) begin
         errors++;
         $display("FAIL req_err sel=%b issend=%b: err=%b required %b", s, isd, err, exp_err);
      end
      @(posedge clk);
      #1;
      request_valid = 1'b0;
   endtask

   // drains the scoreboards cycle by cycle; t counts cycles after the accept cycle
   task automatic score_transfer(input int budget, input int exp_fin, input int inj_cyc,
                                 input int abort_wr, output bit aborted);
      int fin_cnt = 0, fin_t = 0, wr_seen = 0, outs = 0;
      bit prev_stall = 0, inj = 0, done = 0;
      logic [31:0] pa = '0, pd = '0;
      logic [121:0] ov;
      req_t e;
      bw_t b;
      aborted = 0;
      for (int t = 1; t <= budget && !done; t++) begin
         @(negedge clk);
         #1;
         if (inj) begin
            request_valid = 1'b0;
            inj = 0;
         end
         #1;
         if (mem_req_valid && mem_req_ready) begin
            checks++;
            if (exp_req.size() == 0) begin
               errors++;
               $display("FAIL mem_req extra: addr=%h we=%b required no request", mem_req_addr, mem_req_we);
            end else begin
               e = exp_req.pop_front();
               if (mem_req_addr !== e.addr || mem_req_we !== e.we || (e.we && mem_req_wdata !== e.wdata)) begin
                  errors++;
                  $display("FAIL mem_req: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                           mem_req_addr, mem_req_we, mem_req_wdata, e.addr, e.we, e.wdata);
               end
            end
         end
         if (prev_stall) begin
            checks++;
            if (!mem_req_valid || mem_req_addr !== pa || mem_req_wdata !== pd) begin
               errors++;
               $display("FAIL stall_hold: valid=%b addr=%h wdata=%h required valid=1 addr=%h wdata=%h",
                        mem_req_valid, mem_req_addr, mem_req_wdata, pa, pd);
            end
         end
         prev_stall = mem_req_valid && mem_req_we && !mem_req_ready;
         pa = mem_req_addr;
         pd = mem_req_wdata;
         if (mem_req_valid && mem_req_ready && !mem_req_we) outs++;
         if (mem_rsp_valid && outs > 0) outs--;
         if (outs > OUTS) begin
            checks++;
            errors++;
            $display("FAIL outstanding: %0d required <= %0d", outs, OUTS);
         end
         if (buf_we) begin
            wr_seen++;
            checks++;
            if (exp_buf.size() == 0) begin
               errors++;
               $display("FAIL buf_write extra: waddr=%0d required no write", buf_waddr);
            end else begin
               b = exp_buf.pop_front();
               if (buf_sel !== b.sel || buf_waddr !== b.waddr || buf_wdata !== b.wdata) begin
                  errors++;
                  $display("FAIL buf_write: sel=%b waddr=%0d wdata=%h required sel=%b waddr=%0d wdata=%h",
                           buf_sel, buf_waddr, buf_wdata, b.sel, b.waddr, b.wdata);
               end
            end
         end
         if (finish) begin
            fin_cnt++;
            fin_t = t;
            checks++;
            if (busy !== 1'b1 || (exp_fin >= 0 && t != exp_fin)) begin
               errors++;
               $display("FAIL finish_cycle: cycle=%0d busy=%b required cycle=%0d busy=1", t, busy, exp_fin);
            end
         end
         if (t == inj_cyc) begin
            request_valid = 1'b1;
            sel = 3'b010;
            issend = 1'b0;
            #1;
            checks++;
            if (err !== 1'b1) begin
               errors++;
               $display("FAIL busy_err: err=%b required 1", err);
            end
            inj = 1;
         end
         if (abort_wr >= 0 && wr_seen == abort_wr) begin
            rst = 1'b1;
            #1;
            ov = {finish, busy, err, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
                  buf_we, buf_sel, buf_waddr, buf_wdata, buf_re, buf_raddr};
            checks++;
            if (ov !== '0) begin
               errors++;
               $display("FAIL reset_outputs: %h required 0", ov);
            end
            aborted = 1;
            done = 1;
         end
         if (fin_cnt > 0 && t >= fin_t + 3) done = 1;
      end
      checks++;
      if (fin_cnt != (aborted ? 0 : 1)) begin
         errors++;
         $display("FAIL finish_count: %0d required %0d", fin_cnt, aborted ? 0 : 1);
      end
      if (!aborted) begin
         checks++;
         if (exp_req.size() != 0 || exp_buf.size() != 0) begin
            errors++;
            $display("FAIL leftover: req=%0d buf=%0d required 0 0", exp_req.size(), exp_buf.size());
         end
      end
   endtask

   task automatic test_reset();
      logic [121:0] ov;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #2;
         ov = {finish, busy, err, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               buf_we, buf_sel, buf_waddr, buf_wdata, buf_re, buf_raddr};
         checks++;
         if (ov !== '0) begin
            errors++;
            $display("FAIL idle_outputs cycle %0d: %h required 0", i, ov);
         end
      end
   endtask

   task automatic test_read_a();
      bit ab;
      lat = 1;
      rdy_mode = 0;
      base_a = 32'h0000_1000;
      push_read(3'b010, base_a, 128);
      issue_req(3'b010, 1'b0, 1'b0);
      score_transfer(400, 131, -1, -1, ab);
   endtask

   task automatic test_read_b();
      bit ab;
      lat = 10;
      rdy_mode = 1;
      base_b = 32'hFFFF_FF00;   // wraps past 2^32 after 64 words
      push_read(3'b100, base_b, 256);
      issue_req(3'b100, 1'b0, 1'b0);
      score_transfer(4000, -1, -1, -1, ab);
      rdy_mode = 0;
   endtask

   task automatic test_writeback();
      bit ab;
      for (int i = 0; i < 256; i++) sram[i] = 32'(i);
      rdy_mode = 2;
      wb_words = 0;
      stall = 0;
      base_d = 32'h0000_8000;
      for (int i = 0; i < 64; i++) exp_req.push_back('{base_d + 32'(4 * i), 1'b1, 32'(i)});
      issue_req(3'b000, 1'b1, 1'b0);
      // 2N+1 with twelve 3-cycle stalls (words 4, 9, ..., 59)
      score_transfer(400, 129 + 36, -1, -1, ab);
      rdy_mode = 0;
   endtask

   task automatic test_err();
      bit ab;
      issue_req(3'b011, 1'b0, 1'b1);
      issue_req(3'b000, 1'b0, 1'b1);
      issue_req(3'b010, 1'b1, 1'b1);
      @(negedge clk);
      #2;
      checks++;
      if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rejected_idle: busy=%b valid=%b required 0 0", busy, mem_req_valid);
      end
      lat = 1;
      base_c = 32'h0000_2000;
      push_read(3'b001, base_c, 64);
      issue_req(3'b001, 1'b0, 1'b0);
      score_transfer(300, 67, 30, -1, ab);
   endtask

   task automatic test_reset_mid();
      bit ab;
      lat = 3;
      base_c = 32'h0000_3000;
      push_read(3'b001, base_c, 64);
      issue_req(3'b001, 1'b0, 1'b0);
      score_transfer(300, -1, -1, 20, ab);
      checks++;
      if (!ab) begin
         errors++;
         $display("FAIL abort_reached: aborted=%b required 1", ab);
      end
      exp_req.delete();
      exp_buf.delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #2;
         checks++;
         if (buf_we !== 1'b0 || finish !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_rsp cycle %0d: buf_we=%b finish=%b valid=%b required 0 0 0",
                     i, buf_we, finish, mem_req_valid);
         end
      end
      base_c = 32'h0000_4000;
      push_read(3'b001, base_c, 64);
      issue_req(3'b001, 1'b0, 1'b0);
      score_transfer(300, 69, -1, -1, ab);
   endtask

   initial begin
      test_reset();
      test_read_a();
      test_read_b();
      test_writeback();
      test_err();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
